main_mem_arb: RTL and testbench
===============================

# main_mem_arb

Two-port access arbiter directly upstream of `main_mem`. Serialises memory requests from the host configuration port and the ADPCM channel engine onto the single-port `main_mem` interface. Engine has priority, with a host starvation guard, and read data is returned to the issuing requester after a fixed latency. Carries the standard scan/test pins so it drops into the same DFT chain as `main_mem`.

## Interface
- `AW`, 8: word address width.
- `DW`, 16: data width.
- `STARVE`, 4: consecutive host denials after which the host wins arbitration; range 1..15.

- `clk`  in  1  system clock; all logic on rising edge.
- `reset`  in  1  asynchronous, active-low system reset.
- `scan_in0..scan_in4`  in  1 each  scan data inputs.
- `scan_enable`  in  1  scan shift enable.
- `test_mode`  in  1  test mode; blocks all grants when 1.
- `scan_out0..scan_out4`  out  1 each  scan data outputs; wired to `scan_in0..4` in RTL until chain insertion.
- `h_req`, `h_we`  in  1  host request / write-not-read.
- `h_addr`  in  AW  host address.
- `h_wdata`  in  DW  host write data.
- `h_gnt`  out  1  host request accepted this cycle.
- `h_rvalid`  out  1  host read data valid.
- `h_rdata`  out  DW  host read data.
- `e_req`, `e_we`, `e_addr`, `e_wdata`, `e_gnt`, `e_rvalid`, `e_rdata`: same as the `h_*` signals, for the engine.
- `mem_cs`, `mem_we`  out  1  memory select / write.
- `mem_addr`  out  AW  memory address.
- `mem_wdata`  out  DW  memory write data.
- `mem_rdata`  in  DW  memory read data; valid one cycle after `mem_cs && !mem_we`.

## Operation
- At most one access is granted per cycle. `*_gnt` is combinational from `*_req`, `test_mode` and `host_wait`.
- A requester holds `req`, `we`, `addr` and `wdata` stable until it sees `gnt` high. It may present a new request the cycle after the grant.
- Arbitration:
  - `test_mode=1`: no grants.
  - Only one requester active: that requester wins.
  - Both active: engine wins, unless `host_wait==STARVE`, in which case the host wins.
- `host_wait` counter (4-bit, saturating at `STARVE`):
  - increments when `h_req && !h_gnt`;
  - clears on `h_gnt` or when `!h_req`.
- The winning request is registered into `mem_*`. `mem_cs=0` in cycles with no grant.
- Read tag pipeline: `{valid, owner}` is captured with each granted read and delayed to align with `mem_rdata`.
  - At tag-valid, the owner's `rvalid` is asserted and its `rdata=mem_rdata`.
  - The non-owner's `rdata` holds 0.
  - Writes generate no `rvalid`.
- Memory ordering equals grant order. A read granted the cycle after a write to the same address returns the written data.

## Timing
- Request at cycle T with grant at T:
  - `mem_*` driven at T+1.
  - `rvalid`/`rdata` at T+2. Read latency is 2 cycles.
- Back-to-back grants give full throughput: one access per cycle.
- Reset (asserted, asynchronous):
  - all outputs 0 except `scan_out*`, which follow `scan_in*`;
  - `host_wait=0`, tag pipeline cleared.
- Reset mid-read: the in-flight read is dropped and no `rvalid` is issued after release.
- `test_mode` rising: no new grants. Reads already granted still complete with `rvalid`.
- `STARVE=1`: with both requesting continuously, grants alternate host/engine.

## Structure
- Package `main_mem_pkg`:
  - `AW`/`DW` defaults;
  - owner enum `OWN_HOST=1'b0`, `OWN_ENG=1'b1`;
  - `STARVE` default;
  - `RD_LAT=1` (memory read latency) constant.
- Sub-module `main_mem_rd_tag`: `RD_LAT`-deep `{valid, owner}` shift register with asynchronous clear. The top level holds the arbiter, `host_wait` and the `mem_*` registers.

## Test plan
- Engine-only read of addr 0x10 (preloaded 0x1234): `e_gnt` at T, `mem_cs=1`/`mem_addr=0x10` at T+1, `e_rvalid=1` with `e_rdata=0x1234` at T+2; `h_rvalid` stays 0.
- Host write 0xBEEF to 0x05 at T, host read of 0x05 at T+1: `h_rdata=0xBEEF` at T+3.
- Both request continuously with `STARVE=4`: engine granted 4 cycles, host the 5th, pattern repeats; `host_wait` returns to 0 after each host grant.
- `test_mode=1` with both requesting: `h_gnt=e_gnt=mem_cs=0` for 10 cycles; `scan_out2` tracks `scan_in2`.
- `reset` low at T+1 after an engine read granted at T: all outputs 0 immediately; no `e_rvalid` after release.
- Engine read at T, host read at T+1 (engine idle): `e_rvalid` at T+2, `h_rvalid` at T+3, each with correct data and never overlapping.

Source files
------------

// File: rtl/main_mem_pkg.sv
// -----------------------------------------------------------------------------
// main_mem_pkg
// Shared types and constants for the main_mem access arbiter:
//   - default address/data widths and host starvation limit
//   - requester owner encoding used by the read tag pipeline
//   - memory read latency (cycles from mem_cs to mem_rdata)
//   - host_wait next-state helper
// -----------------------------------------------------------------------------
package main_mem_pkg;

  localparam int unsigned AW_DEFAULT     = 8;
  localparam int unsigned DW_DEFAULT     = 16;
  localparam int unsigned STARVE_DEFAULT = 4;
  localparam int unsigned RD_LAT         = 1;
  localparam int unsigned HW_W           = 4;

  typedef enum logic {
    OWN_HOST = 1'b0,
    OWN_ENG  = 1'b1
  } owner_e;

  typedef struct packed {
    logic   valid;
    owner_e owner;
  } rd_tag_t;

  // host_wait counts consecutive cycles the host asked and was refused,
  // saturating at the starvation limit; any grant or idle cycle clears it.
  function automatic logic [HW_W-1:0] host_wait_next(
    input logic [HW_W-1:0] cur,
    input logic            req,
    input logic            gnt,
    input logic [HW_W-1:0] limit
  );
    logic [HW_W-1:0] nxt;
    nxt = 4'd0;
    if (!req || gnt) begin
      nxt = 4'd0;
    end else if (cur >= limit) begin
      nxt = limit;
    end else begin
      nxt = cur + 4'd1;
    end
    return nxt;
  endfunction

endpackage

// File: rtl/main_mem_rd_tag.sv
// -----------------------------------------------------------------------------
// main_mem_rd_tag
// Delay line for the {valid, owner} tag of each read issued to main_mem, so the
// tag emerges in the same cycle as the corresponding mem_rdata.
// Ports:
//   clk    in   system clock
//   rst_n  in   asynchronous active-low clear (drops in-flight tags)
//   tag_i  in   tag of the access currently on the mem_* bus
//   tag_o  out  tag aligned with mem_rdata
// -----------------------------------------------------------------------------
module main_mem_rd_tag
  import main_mem_pkg::*;
#(
  parameter int DEPTH = int'(RD_LAT)
) (
  input  logic    clk,
  input  logic    rst_n,
  input  rd_tag_t tag_i,
  output rd_tag_t tag_o
);

  rd_tag_t pipe_q [DEPTH];

  // Tag shift register; reset empties every stage so no stale rvalid escapes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        pipe_q[i] <= '0;
      end
    end else begin
      pipe_q[0] <= tag_i;
      for (int i = 1; i < DEPTH; i++) begin
        pipe_q[i] <= pipe_q[i-1];
      end
    end
  end

  assign tag_o = pipe_q[DEPTH-1];

endmodule

// File: rtl/main_mem_arb.sv
// -----------------------------------------------------------------------------
// main_mem_arb
// Serialises host and ADPCM engine accesses onto the single-port main_mem.
// Engine has priority; after STARVE consecutive refusals the host wins once.
// Grants are combinational; the winning access is registered onto mem_*, and
// read data is steered back to the issuing requester two cycles after grant.
// Ports:
//   clk, reset                 clock, asynchronous active-low reset
//   scan_in0..4, scan_enable,
//   test_mode, scan_out0..4    DFT pins; test_mode blocks all grants,
//                              scan_out* mirror scan_in* until chain insertion
//   h_req/h_we/h_addr/h_wdata  host request
//   h_gnt/h_rvalid/h_rdata     host grant and read return
//   e_*                        same set for the engine
//   mem_cs/we/addr/wdata       registered memory command
//   mem_rdata                  memory read data, one cycle after a read command
// -----------------------------------------------------------------------------
module main_mem_arb
  import main_mem_pkg::*;
#(
  parameter int unsigned AW     = AW_DEFAULT,
  parameter int unsigned DW     = DW_DEFAULT,
  parameter int unsigned STARVE = STARVE_DEFAULT
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          scan_in0,
  input  logic          scan_in1,
  input  logic          scan_in2,
  input  logic          scan_in3,
  input  logic          scan_in4,
  input  logic          scan_enable,
  input  logic          test_mode,
  output logic          scan_out0,
  output logic          scan_out1,
  output logic          scan_out2,
  output logic          scan_out3,
  output logic          scan_out4,
  input  logic          h_req,
  input  logic          h_we,
  input  logic [AW-1:0] h_addr,
  input  logic [DW-1:0] h_wdata,
  output logic          h_gnt,
  output logic          h_rvalid,
  output logic [DW-1:0] h_rdata,
  input  logic          e_req,
  input  logic          e_we,
  input  logic [AW-1:0] e_addr,
  input  logic [DW-1:0] e_wdata,
  output logic          e_gnt,
  output logic          e_rvalid,
  output logic [DW-1:0] e_rdata,
  output logic          mem_cs,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata
);

  localparam logic [HW_W-1:0] STARVE_LIM = HW_W'(STARVE);

  logic [HW_W-1:0] host_wait_q, host_wait_d;
  logic            grant_ok_s, starved_s;
  logic            h_gnt_s, e_gnt_s;

  logic            mem_cs_q, mem_cs_d;
  logic            mem_we_q, mem_we_d;
  logic [AW-1:0]   mem_addr_q, mem_addr_d;
  logic [DW-1:0]   mem_wdata_q, mem_wdata_d;
  owner_e          mem_owner_q, mem_owner_d;

  rd_tag_t         tag_in_s, tag_out_s;
  logic            dft_unused_s;

  // Scan chain is stitched at insertion; until then data passes straight through.
  assign scan_out0    = scan_in0;
  assign scan_out1    = scan_in1;
  assign scan_out2    = scan_in2;
  assign scan_out3    = scan_in3;
  assign scan_out4    = scan_in4;
  assign dft_unused_s = scan_enable;

  // Grants are also suppressed while reset is held so every output reads 0.
  assign grant_ok_s = reset && !test_mode;
  assign starved_s  = (host_wait_q == STARVE_LIM);

  // Arbitration: engine first unless the host has waited STARVE cycles.
  always_comb begin
    h_gnt_s = 1'b0;
    e_gnt_s = 1'b0;
    if (grant_ok_s) begin
      if (h_req && (!e_req || starved_s)) begin
        h_gnt_s = 1'b1;
      end else if (e_req) begin
        e_gnt_s = 1'b1;
      end else begin
        h_gnt_s = 1'b0;
        e_gnt_s = 1'b0;
      end
    end else begin
      h_gnt_s = 1'b0;
      e_gnt_s = 1'b0;
    end
  end

  assign h_gnt = h_gnt_s;
  assign e_gnt = e_gnt_s;

  // Starvation counter next state.
  always_comb begin
    host_wait_d = host_wait_next(host_wait_q, h_req, h_gnt_s, STARVE_LIM);
  end

  // Select the winning request for the memory command register.
  always_comb begin
    mem_cs_d    = 1'b0;
    mem_we_d    = 1'b0;
    mem_addr_d  = '0;
    mem_wdata_d = '0;
    mem_owner_d = OWN_HOST;
    if (h_gnt_s) begin
      mem_cs_d    = 1'b1;
      mem_we_d    = h_we;
      mem_addr_d  = h_addr;
      mem_wdata_d = h_wdata;
      mem_owner_d = OWN_HOST;
    end else if (e_gnt_s) begin
      mem_cs_d    = 1'b1;
      mem_we_d    = e_we;
      mem_addr_d  = e_addr;
      mem_wdata_d = e_wdata;
      mem_owner_d = OWN_ENG;
    end else begin
      mem_cs_d    = 1'b0;
    end
  end

  // Arbiter state and registered memory command.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      host_wait_q <= 4'd0;
      mem_cs_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_owner_q <= OWN_HOST;
    end else begin
      host_wait_q <= host_wait_d;
      mem_cs_q    <= mem_cs_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_owner_q <= mem_owner_d;
    end
  end

  assign mem_cs    = mem_cs_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;

  // The tag enters alongside the command on mem_*, so it leaves the delay line
  // exactly when the memory presents the read data.
  assign tag_in_s = '{valid: mem_cs_q && !mem_we_q, owner: mem_owner_q};

  main_mem_rd_tag #(
    .DEPTH (int'(RD_LAT))
  ) u_rd_tag (
    .clk   (clk),
    .rst_n (reset),
    .tag_i (tag_in_s),
    .tag_o (tag_out_s)
  );

  // Steer read data to its owner; the other side is held at zero.
  always_comb begin
    h_rvalid = tag_out_s.valid && (tag_out_s.owner == OWN_HOST);
    e_rvalid = tag_out_s.valid && (tag_out_s.owner == OWN_ENG);
    h_rdata  = '0;
    e_rdata  = '0;
    if (h_rvalid) begin
      h_rdata = mem_rdata;
    end else begin
      h_rdata = '0;
    end
    if (e_rvalid) begin
      e_rdata = mem_rdata;
    end else begin
      e_rdata = '0;
    end
  end

endmodule

// File: tb/tb_main_mem_arb.sv
// -----------------------------------------------------------------------------
// tb_main_mem_arb
// Table of single-cycle request vectors plus hand-written sequences for
// starvation, test_mode and reset. Expected memory commands and read returns
// are queued when a grant is expected and compared when they fall due.
// -----------------------------------------------------------------------------
module tb_main_mem_arb;

  localparam int STARVE = 4;

  logic        clk;
  logic        reset;
  logic [4:0]  scan_in_v;
  logic        scan_enable, test_mode;
  logic        scan_out0, scan_out1, scan_out2, scan_out3, scan_out4;
  logic        h_req, h_we, e_req, e_we;
  logic [7:0]  h_addr, e_addr;
  logic [15:0] h_wdata, e_wdata;
  logic        h_gnt, h_rvalid, e_gnt, e_rvalid;
  logic [15:0] h_rdata, e_rdata;
  logic        mem_cs, mem_we;
  logic [7:0]  mem_addr;
  logic [15:0] mem_wdata, mem_rdata;

  main_mem_arb #(.AW(8), .DW(16), .STARVE(STARVE)) dut (
    .clk(clk), .reset(reset),
    .scan_in0(scan_in_v[0]), .scan_in1(scan_in_v[1]), .scan_in2(scan_in_v[2]),
    .scan_in3(scan_in_v[3]), .scan_in4(scan_in_v[4]),
    .scan_enable(scan_enable), .test_mode(test_mode),
    .scan_out0(scan_out0), .scan_out1(scan_out1), .scan_out2(scan_out2),
    .scan_out3(scan_out3), .scan_out4(scan_out4),
    .h_req(h_req), .h_we(h_we), .h_addr(h_addr), .h_wdata(h_wdata),
    .h_gnt(h_gnt), .h_rvalid(h_rvalid), .h_rdata(h_rdata),
    .e_req(e_req), .e_we(e_we), .e_addr(e_addr), .e_wdata(e_wdata),
    .e_gnt(e_gnt), .e_rvalid(e_rvalid), .e_rdata(e_rdata),
    .mem_cs(mem_cs), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  typedef struct {
    logic hr; logic hw; logic [7:0] ha; logic [15:0] hd;
    logic er; logic ew; logic [7:0] ea; logic [15:0] ed;
    logic tm; logic xh; logic xe;
  } vec_t;

  typedef struct { int due; logic own; logic [15:0] data; } rexp_t;
  typedef struct { int due; logic we; logic [7:0] a; logic [15:0] d; } mexp_t;

  rexp_t       rq[$];
  mexp_t       mq[$];
  logic [15:0] mem_model [256];
  logic [15:0] shadow [256];
  vec_t        tbl [19];
  int          n_vec, n_err, cyc;
  logic [3:0]  hw_m;

  logic        exp_hv, exp_ev;
  logic [15:0] exp_hd, exp_ed;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Simple synchronous memory stand-in with one cycle read latency.
  always @(posedge clk) begin
    if (mem_cs) begin
      if (mem_we) mem_model[mem_addr] <= mem_wdata;
      else        mem_rdata <= mem_model[mem_addr];
    end
  end

  function automatic logic [15:0] init_val(input logic [7:0] a);
    return (a == 8'h10) ? 16'h1234 : {a ^ 8'hA5, a};
  endfunction

  function automatic vec_t mk(input logic hr, input logic hw, input logic [7:0] ha,
                              input logic [15:0] hd, input logic er, input logic ew,
                              input logic [7:0] ea, input logic [15:0] ed,
                              input logic tm, input logic xh, input logic xe);
    vec_t v;
    v.hr = hr; v.hw = hw; v.ha = ha; v.hd = hd;
    v.er = er; v.ew = ew; v.ea = ea; v.ed = ed;
    v.tm = tm; v.xh = xh; v.xe = xe;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // One request cycle: drive, check grants, queue expected consequences.
  task automatic step(input vec_t v, input string nm);
    @(posedge clk); #1;
    h_req = v.hr; h_we = v.hw; h_addr = v.ha; h_wdata = v.hd;
    e_req = v.er; e_we = v.ew; e_addr = v.ea; e_wdata = v.ed;
    test_mode = v.tm;
    scan_in_v = 5'($urandom);
    @(negedge clk);
    chk({nm, " h_gnt"}, 32'(h_gnt), 32'(v.xh));
    chk({nm, " e_gnt"}, 32'(e_gnt), 32'(v.xe));
    chk({nm, " host_wait"}, 32'(dut.host_wait_q), 32'(hw_m));
    chk({nm, " scan_out"}, 32'({scan_out4, scan_out3, scan_out2, scan_out1, scan_out0}),
        32'(scan_in_v));
    if (v.xh) begin
      mq.push_back('{cyc + 1, v.hw, v.ha, v.hd});
      if (v.hw) shadow[v.ha] = v.hd;
      else      rq.push_back('{cyc + 2, 1'b0, shadow[v.ha]});
    end else if (v.xe) begin
      mq.push_back('{cyc + 1, v.ew, v.ea, v.ed});
      if (v.ew) shadow[v.ea] = v.ed;
      else      rq.push_back('{cyc + 2, 1'b1, shadow[v.ea]});
    end
    if (!v.hr || v.xh) hw_m = 4'd0;
    else if (hw_m < 4'(STARVE)) hw_m = hw_m + 4'd1;
  endtask

  task automatic check_all_zero(input string nm);
    chk({nm, " h_gnt"}, 32'(h_gnt), 32'd0);
    chk({nm, " e_gnt"}, 32'(e_gnt), 32'd0);
    chk({nm, " mem_cs"}, 32'(mem_cs), 32'd0);
    chk({nm, " mem_we"}, 32'(mem_we), 32'd0);
    chk({nm, " mem_addr"}, 32'(mem_addr), 32'd0);
    chk({nm, " mem_wdata"}, 32'(mem_wdata), 32'd0);
    chk({nm, " h_rvalid"}, 32'(h_rvalid), 32'd0);
    chk({nm, " e_rvalid"}, 32'(e_rvalid), 32'd0);
    chk({nm, " h_rdata"}, 32'(h_rdata), 32'd0);
    chk({nm, " e_rdata"}, 32'(e_rdata), 32'd0);
    chk({nm, " host_wait"}, 32'(dut.host_wait_q), 32'd0);
    chk({nm, " scan_out"}, 32'({scan_out4, scan_out3, scan_out2, scan_out1, scan_out0}),
        32'(scan_in_v));
  endtask

  // Scoreboard: compare memory commands and read returns as they fall due.
  always @(negedge clk) begin
    if (mq.size() > 0 && mq[0].due == cyc) begin
      chk("mem_cs", 32'(mem_cs), 32'd1);
      chk("mem_we", 32'(mem_we), 32'(mq[0].we));
      chk("mem_addr", 32'(mem_addr), 32'(mq[0].a));
      if (mq[0].we) chk("mem_wdata", 32'(mem_wdata), 32'(mq[0].d));
      void'(mq.pop_front());
    end else begin
      chk("mem_cs idle", 32'(mem_cs), 32'd0);
    end
    exp_hv = 1'b0; exp_ev = 1'b0; exp_hd = 16'h0000; exp_ed = 16'h0000;
    if (rq.size() > 0 && rq[0].due == cyc) begin
      if (rq[0].own) begin exp_ev = 1'b1; exp_ed = rq[0].data; end
      else           begin exp_hv = 1'b1; exp_hd = rq[0].data; end
      void'(rq.pop_front());
    end
    chk("h_rvalid", 32'(h_rvalid), 32'(exp_hv));
    chk("e_rvalid", 32'(e_rvalid), 32'(exp_ev));
    chk("h_rdata", 32'(h_rdata), 32'(exp_hd));
    chk("e_rdata", 32'(e_rdata), 32'(exp_ed));
  end

  initial begin
    vec_t v;
    logic [7:0] ha, ea;
    logic       xh;
    n_vec = 0; n_err = 0; cyc = 0; hw_m = 4'd0;
    reset = 1'b1; scan_in_v = 5'd0; scan_enable = 1'b0; test_mode = 1'b0;
    h_req = 1'b0; h_we = 1'b0; h_addr = 8'h00; h_wdata = 16'h0000;
    e_req = 1'b0; e_we = 1'b0; e_addr = 8'h00; e_wdata = 16'h0000;
    for (int i = 0; i < 256; i++) begin
      mem_model[i] = init_val(8'(i));
      shadow[i]    = init_val(8'(i));
    end
    mem_rdata = 16'h0000;

    tbl[0]  = mk(1'b0, 1'b0, 8'h00, 16'h0000, 1'b1, 1'b0, 8'h10, 16'h0000, 1'b0, 1'b0, 1'b1);
    tbl[1]  = mk(1'b0, 1'b0, 8'h00, 16'h0000, 1'b0, 1'b0, 8'h00, 16'h0000, 1'b0, 1'b0, 1'b0);
    tbl[2]  = mk(1'b1, 1'b1, 8'h05, 16'hBEEF, 1'b0, 1'b0, 8'h00, 16'h0000, 1'b0, 1'b1, 1'b0);
    tbl[3]  = mk(1'b1, 1'b0, 8'h05, 16'h0000, 1'b0, 1'b0, 8'h00, 16'h0000, 1'b0, 1'b1, 1'b0);
    tbl[4]  = mk(1'b0, 1'b0, 8'h00, 16'h0000, 1'b1, 1'b1, 8'h22, 16'hCAFE, 1'b0, 1'b0, 1'b1);
    tbl[5]  = mk(1'b0, 1'b0, 8'h00, 16'h0000, 1'b1, 1'b0, 8'h22, 16'h0000, 1'b0, 1'b0, 1'b1);
    tbl[6]  = mk(1'b1, 1'b0, 8'h30, 16'h0000, 1'b0, 1'b0, 8'h00, 16'h0000, 1'b0, 1'b1, 1'b0);
    tbl[7]  = mk(1'b1, 1'b0, 8'h40, 16'h0000, 1'b1, 1'b0, 8'h41, 16'h0000, 1'b0, 1'b0, 1'b1);
    tbl[8]  = mk(1'b1, 1'b0, 8'h40, 16'h0000, 1'b1, 1'b0, 8'h42, 16'h0000, 1'b0, 1'b0, 1'b1);
    tbl[9]  = mk(1'b1, 1'b0, 8'h40, 16'h0000, 1'b1, 1'b0, 8'h43, 16'h0000, 1'b1, 1'b0, 1'b0);
    tbl[10] = mk(1'b1, 1'b0, 8'h40, 16'h0000, 1'b0, 1'b0, 8'h00, 16'h0000, 1'b0, 1'b1, 1'b0);
    tbl[11] = mk(1'b0, 1'b0, 8'h00, 16'h0000, 1'b1, 1'b0, 8'h11, 16'h0000, 1'b0, 1'b0, 1'b1);
    tbl[12] = mk(1'b1, 1'b0, 8'h12, 16'h0000, 1'b0, 1'b0, 8'h00, 16'h0000, 1'b0, 1'b1, 1'b0);
    tbl[13] = mk(1'b1, 1'b1, 8'h50, 16'h1111, 1'b1, 1'b1, 8'h51, 16'h2222, 1'b0, 1'b0, 1'b1);
    tbl[14] = mk(1'b1, 1'b1, 8'h50, 16'h1111, 1'b0, 1'b0, 8'h00, 16'h0000, 1'b0, 1'b1, 1'b0);
    tbl[15] = mk(1'b1, 1'b0, 8'h50, 16'h0000, 1'b0, 1'b0, 8'h00, 16'h0000, 1'b0, 1'b1, 1'b0);
    tbl[16] = mk(1'b0, 1'b0, 8'h00, 16'h0000, 1'b1, 1'b0, 8'h51, 16'h0000, 1'b0, 1'b0, 1'b1);
    tbl[17] = mk(1'b0, 1'b0, 8'h00, 16'h0000, 1'b0, 1'b0, 8'h00, 16'h0000, 1'b0, 1'b0, 1'b0);
    tbl[18] = tbl[17];

    // Power-on reset: outputs quiet, scan pins pass through.
    #2 reset = 1'b0;
    @(posedge clk); #1;
    scan_in_v = 5'b10110;
    #1 check_all_zero("por");
    @(posedge clk); #1 reset = 1'b1;

    // Table of single-cycle vectors.
    for (int i = 0; i < 19; i++) step(tbl[i], $sformatf("vec%0d", i));

    // Both requesting continuously: engine four times, then the host.
    ha = 8'h60; ea = 8'h80;
    for (int k = 0; k < 15; k++) begin
      xh = (hw_m == 4'(STARVE));
      v = mk(1'b1, 1'b0, ha, 16'h0000, 1'b1, 1'b0, ea, 16'h0000, 1'b0, xh, !xh);
      step(v, $sformatf("starve%0d", k));
      if (xh) ha = ha + 8'd1;
      ea = ea + 8'd1;
    end

    // test_mode: no grants for 10 cycles; reads already in flight still return.
    for (int k = 0; k < 10; k++) begin
      v = mk(1'b1, 1'b0, ha, 16'h0000, 1'b1, 1'b0, ea, 16'h0000, 1'b1, 1'b0, 1'b0);
      step(v, $sformatf("tmode%0d", k));
    end
    // Leaving test_mode with host_wait saturated: host wins straight away.
    xh = (hw_m == 4'(STARVE));
    v = mk(1'b1, 1'b0, ha, 16'h0000, 1'b1, 1'b0, ea, 16'h0000, 1'b0, xh, !xh);
    step(v, "tm_exit");
    chk("tm_exit host wins", 32'(xh), 32'd1);

    // Reset while an engine read is in flight.
    v = mk(1'b0, 1'b0, 8'h00, 16'h0000, 1'b1, 1'b0, 8'h10, 16'h0000, 1'b0, 1'b0, 1'b1);
    step(v, "pre_rst");
    @(posedge clk); #1;
    reset = 1'b0;
    rq.delete(); mq.delete(); hw_m = 4'd0;
    scan_in_v = 5'b01101;
    #1 check_all_zero("mid_rst");
    @(posedge clk); #1;
    reset = 1'b1; e_req = 1'b0;
    for (int k = 0; k < 4; k++) step(tbl[17], $sformatf("post_rst%0d", k));

    chk("rq drained", 32'(rq.size()), 32'd0);
    chk("mq drained", 32'(mq.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
